tra_safety_monitor: RTL and testbench
=====================================

TRA_SAFETY_MONITOR -- requirements
Module: tra_safety_monitor

Interface
REQ-001 Parameter MAX_GREEN, default 200: maximum consecutive sampled cycles either car light may be GREEN; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ns_car  input  2  north-south car light code.
REQ-005 ns_hmn  input  2  north-south pedestrian light code.
REQ-006 ew_car  input  2  east-west car light code.
REQ-007 ew_hmn  input  2  east-west pedestrian light code.
REQ-008 clear  input  1  acknowledge; releases FAULT state.
REQ-009 fault  output  1  high while in FAULT.
REQ-010 fault_code  output  3  latched cause of the current or most recent fault.
REQ-011 fault_cnt  output  8  number of faults since reset; saturates at 255.
REQ-012 cycle  output  7  completed north-south signal cycles; wraps 127->0.
REQ-013 cycle_pulse  output  1  one-cycle strobe when cycle increments.

Function
REQ-014 Car codes: 00 RED, 01 YELLOW, 10 GREEN, 11 INVALID; pedestrian codes: 00 STOP, 01 FLASH, 10 WALK, 11 INVALID.
REQ-015 States: IDLE, RUN, FAULT; IDLE->RUN on the first edge sampling ns_car=RED and ew_car=RED; no checks run in IDLE.
REQ-016 In RUN, each edge evaluates the current inputs against the previous sampled values; the previous registers update on every edge.
REQ-017 Fault causes and fault_code: 1 any INVALID code; 2 ns_car and ew_car both non-RED; 3 ns_hmn=WALK with ew_car non-RED, or ew_hmn=WALK with ns_car non-RED; 4 illegal car transition; 5 green timeout.
REQ-018 Legal car transitions are hold, RED->GREEN, GREEN->YELLOW and YELLOW->RED; all others are code 4.
REQ-019 Simultaneous causes: the lowest code number wins.
REQ-020 Green timer: 16-bit counter incremented on each RUN edge where either car is GREEN, cleared when neither is GREEN; code 5 on the (MAX_GREEN+1)-th consecutive GREEN sample.
REQ-021 Detection in RUN: fault, fault_code, fault_cnt+1 and FAULT state are all registered on the same edge that samples the offending inputs; latency is 0 cycles after that edge.
REQ-022 In FAULT, checks, timer and cycle counter freeze, and fault_code holds.
REQ-023 FAULT->IDLE on an edge with clear=1; fault falls on that edge; fault_code and fault_cnt are retained.
REQ-024 clear in IDLE or RUN has no effect.
REQ-025 Cycle count: in RUN, when ns_car goes RED->GREEN with no fault on that edge, cycle increments and cycle_pulse is high for exactly that cycle.
REQ-026 fault_cnt holds at 255 on further faults.

Reset
REQ-027 rst=1 forces state IDLE, fault=0, fault_code=0, fault_cnt=0, cycle=0, cycle_pulse=0, timer=0 and previous-value registers=RED/STOP, immediately and without a clock.
REQ-028 rst asserted mid-FAULT or mid-cycle discards all state; after release the monitor waits in IDLE for all-red.

Structure
REQ-029 Package tra_pkg holds the light encodings, the fault code constants and the monitor state enumeration.
REQ-030 Sub-module tra_trans_check (previous-value register plus legal-transition check for one car light) is instantiated twice, once for NS and once for EW.

Verification
REQ-031 Scenario 1: reset, all-red, then a legal NS sequence (G x5, Y x2, R x2) followed by the same EW sequence, repeated 3 times -> fault=0 throughout, cycle=3, three cycle_pulse strobes.
REQ-032 Scenario 2: in RUN, ns_car=GREEN and ew_car=YELLOW on the same edge -> fault=1 on that edge, fault_code=2, fault_cnt=1.
REQ-033 Scenario 3: ns_car GREEN->RED directly together with ew_hmn=11 -> fault_code=1 (priority); apply clear -> fault=0 and state IDLE; fault_code stays 1.
REQ-034 Scenario 4: MAX_GREEN=4, hold ns_car=GREEN -> no fault on samples 1-4, fault_code=5 on sample 5.
REQ-035 Scenario 5: drive 130 legal NS cycles -> cycle wraps 127->0->2. Force 256 faults with clears between them -> fault_cnt=255.
REQ-036 Scenario 6: assert rst between clock edges while in FAULT -> all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/tra_pkg.sv
// Shared encodings for the traffic-light safety monitor: light codes, fault
// causes, monitor states and the car-light transition rule.
package tra_pkg;

   localparam logic [1:0] CAR_RED     = 2'b00;
   localparam logic [1:0] CAR_YELLOW  = 2'b01;
   localparam logic [1:0] CAR_GREEN   = 2'b10;
   localparam logic [1:0] CAR_INVALID = 2'b11;

   localparam logic [1:0] PED_STOP    = 2'b00;
   localparam logic [1:0] PED_FLASH   = 2'b01;
   localparam logic [1:0] PED_WALK    = 2'b10;
   localparam logic [1:0] PED_INVALID = 2'b11;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_INVALID  = 3'd1;
   localparam logic [2:0] FC_BOTH_GO  = 3'd2;
   localparam logic [2:0] FC_WALK     = 3'd3;
   localparam logic [2:0] FC_TRANS    = 3'd4;
   localparam logic [2:0] FC_TIMEOUT  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } tra_state_e;

   // A car light may hold, or step forward RED->GREEN->YELLOW->RED.
   function automatic logic car_legal(input logic [1:0] prev, input logic [1:0] cur);
      car_legal = (cur == prev) ||
                  (prev == CAR_RED    && cur == CAR_GREEN)  ||
                  (prev == CAR_GREEN  && cur == CAR_YELLOW) ||
                  (prev == CAR_YELLOW && cur == CAR_RED);
   endfunction

endpackage

// File: rtl/tra_trans_check.sv
// Previous-value register and legal-transition check for one car light.
module tra_trans_check
   import tra_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cur,
   output logic       legal,
   output logic       rise
);

   logic [1:0] prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= CAR_RED;
      else     prev <= cur;
   end

   assign legal = car_legal(prev, cur);
   assign rise  = (prev == CAR_RED) && (cur == CAR_GREEN);

endmodule

// File: rtl/tra_safety_monitor.sv
// Safety monitor for a two-way intersection: detects unsafe light combinations,
// latches the cause, counts faults and completed north-south cycles.
module tra_safety_monitor
   import tra_pkg::*;
#(
   parameter int unsigned MAX_GREEN = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ns_car,
   input  logic [1:0] ns_hmn,
   input  logic [1:0] ew_car,
   input  logic [1:0] ew_hmn,
   input  logic       clear,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [7:0] fault_cnt,
   output logic [6:0] cycle,
   output logic       cycle_pulse,
   output tra_state_e state
);

   localparam logic [15:0] MAX_G = MAX_GREEN[15:0];

   logic        ns_legal, ew_legal;
   logic        ns_rise, ew_rise_unused;
   logic        any_green;
   logic [15:0] timer;
   logic [2:0]  det_code;

   tra_trans_check u_ns_check (
      .clk   (clk),
      .rst   (rst),
      .cur   (ns_car),
      .legal (ns_legal),
      .rise  (ns_rise)
   );

   tra_trans_check u_ew_check (
      .clk   (clk),
      .rst   (rst),
      .cur   (ew_car),
      .legal (ew_legal),
      .rise  (ew_rise_unused)
   );

   assign any_green = (ns_car == CAR_GREEN) || (ew_car == CAR_GREEN);

   // Priority chain: the lowest-numbered cause wins when several coincide.
   always_comb begin
      det_code = FC_NONE;
      if (ns_car == CAR_INVALID || ew_car == CAR_INVALID ||
          ns_hmn == PED_INVALID || ew_hmn == PED_INVALID)
         det_code = FC_INVALID;
      else if (ns_car != CAR_RED && ew_car != CAR_RED)
         det_code = FC_BOTH_GO;
      else if ((ns_hmn == PED_WALK && ew_car != CAR_RED) ||
               (ew_hmn == PED_WALK && ns_car != CAR_RED))
         det_code = FC_WALK;
      else if (!ns_legal || !ew_legal)
         det_code = FC_TRANS;
      else if (any_green && timer >= MAX_G)
         det_code = FC_TIMEOUT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         fault       <= 1'b0;
         fault_code  <= FC_NONE;
         fault_cnt   <= 8'd0;
         cycle       <= 7'd0;
         cycle_pulse <= 1'b0;
         timer       <= 16'd0;
      end else begin
         cycle_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               timer <= 16'd0;
               if (ns_car == CAR_RED && ew_car == CAR_RED) state <= ST_RUN;
            end
            ST_RUN: begin
               if (det_code != FC_NONE) begin
                  state      <= ST_FAULT;
                  fault      <= 1'b1;
                  fault_code <= det_code;
                  if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
               end else begin
                  timer <= any_green ? timer + 16'd1 : 16'd0;
                  if (ns_rise) begin
                     cycle       <= cycle + 7'd1;
                     cycle_pulse <= 1'b1;
                  end
               end
            end
            ST_FAULT: begin
               // Everything but the clear handshake is frozen here.
               if (clear) begin
                  state <= ST_IDLE;
                  fault <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tra_safety_monitor.sv
// Directed bench for tra_safety_monitor; a second instance uses MAX_GREEN=4
// to reach the green-timeout boundary quickly.
module tb_tra_safety_monitor;
   import tra_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] ns_car = CAR_RED, ns_hmn = PED_STOP, ew_car = CAR_RED, ew_hmn = PED_STOP;
   logic       clear = 1'b0;

   logic       fault, fault4;
   logic [2:0] fault_code, fault_code4;
   logic [7:0] fault_cnt, fault_cnt4;
   logic [6:0] cycle, cycle4;
   logic       cycle_pulse, cycle_pulse4;
   tra_state_e st, st4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tra_safety_monitor dut (
      .clk(clk), .rst(rst), .ns_car(ns_car), .ns_hmn(ns_hmn), .ew_car(ew_car),
      .ew_hmn(ew_hmn), .clear(clear), .fault(fault), .fault_code(fault_code),
      .fault_cnt(fault_cnt), .cycle(cycle), .cycle_pulse(cycle_pulse), .state(st)
   );

   tra_safety_monitor #(.MAX_GREEN(4)) dut4 (
      .clk(clk), .rst(rst), .ns_car(ns_car), .ns_hmn(ns_hmn), .ew_car(ew_car),
      .ew_hmn(ew_hmn), .clear(clear), .fault(fault4), .fault_code(fault_code4),
      .fault_cnt(fault_cnt4), .cycle(cycle4), .cycle_pulse(cycle_pulse4), .state(st4)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one input vector, clock it in, and return 1 time unit after the edge.
   task automatic step(input logic [1:0] nc, input logic [1:0] ec,
                       input logic [1:0] nh, input logic [1:0] eh, input logic clr);
      ns_car = nc; ew_car = ec; ns_hmn = nh; ew_hmn = eh; clear = clr;
      @(posedge clk); #1;
   endtask

   task automatic cars(input logic [1:0] nc, input logic [1:0] ec);
      step(nc, ec, PED_STOP, PED_STOP, 1'b0);
   endtask

   task automatic do_reset();
      ns_car = CAR_RED; ew_car = CAR_RED; ns_hmn = PED_STOP; ew_hmn = PED_STOP; clear = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   int   pulses;
   logic seen_fault;

   task automatic track();
      pulses = pulses + int'(cycle_pulse);
      seen_fault = seen_fault | fault;
   endtask

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_fault", int'(fault), 0);
      check_eq("rst_code", int'(fault_code), 0);
      check_eq("rst_cnt", int'(fault_cnt), 0);
      check_eq("rst_cycle", int'(cycle), 0);
      check_eq("rst_state", int'(st), int'(ST_IDLE));

      // Scenario 1: three legal NS then EW sequences
      cars(CAR_RED, CAR_RED);
      check_eq("s1_run", int'(st), int'(ST_RUN));
      pulses = 0; seen_fault = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) begin cars(CAR_GREEN, CAR_RED);  track(); end
         for (int i = 0; i < 2; i++) begin cars(CAR_YELLOW, CAR_RED); track(); end
         for (int i = 0; i < 2; i++) begin cars(CAR_RED, CAR_RED);    track(); end
         for (int i = 0; i < 5; i++) begin cars(CAR_RED, CAR_GREEN);  track(); end
         for (int i = 0; i < 2; i++) begin cars(CAR_RED, CAR_YELLOW); track(); end
         for (int i = 0; i < 2; i++) begin cars(CAR_RED, CAR_RED);    track(); end
         check_eq("s1_cycle_step", int'(cycle), r + 1);
      end
      check_eq("s1_no_fault", int'(seen_fault), 0);
      check_eq("s1_cycle", int'(cycle), 3);
      check_eq("s1_pulses", pulses, 3);

      // Scenario 2: both car directions non-red
      cars(CAR_GREEN, CAR_YELLOW);
      check_eq("s2_fault", int'(fault), 1);
      check_eq("s2_code", int'(fault_code), 2);
      check_eq("s2_cnt", int'(fault_cnt), 1);
      check_eq("s2_state", int'(st), int'(ST_FAULT));
      cars(CAR_GREEN, CAR_GREEN);
      check_eq("s2_code_hold", int'(fault_code), 2);
      check_eq("s2_cnt_hold", int'(fault_cnt), 1);

      // Scenario 3: priority of invalid code over illegal transition, then clear
      step(CAR_RED, CAR_RED, PED_STOP, PED_STOP, 1'b1);
      check_eq("s3_clear1", int'(st), int'(ST_IDLE));
      cars(CAR_RED, CAR_RED);
      cars(CAR_GREEN, CAR_RED);
      step(CAR_RED, CAR_RED, PED_STOP, PED_INVALID, 1'b0);
      check_eq("s3_fault", int'(fault), 1);
      check_eq("s3_code", int'(fault_code), 1);
      check_eq("s3_cnt", int'(fault_cnt), 2);
      step(CAR_RED, CAR_RED, PED_STOP, PED_STOP, 1'b1);
      check_eq("s3_clr_fault", int'(fault), 0);
      check_eq("s3_clr_state", int'(st), int'(ST_IDLE));
      check_eq("s3_clr_code", int'(fault_code), 1);
      check_eq("s3_clr_cnt", int'(fault_cnt), 2);
      cars(CAR_RED, CAR_RED);
      step(CAR_RED, CAR_RED, PED_STOP, PED_STOP, 1'b1);
      check_eq("s3_clr_in_run", int'(st), int'(ST_RUN));
      // Walk against moving traffic
      cars(CAR_GREEN, CAR_RED);
      step(CAR_GREEN, CAR_RED, PED_STOP, PED_WALK, 1'b0);
      check_eq("s3_walk_code", int'(fault_code), 3);

      // Scenario 4: green timeout boundary with MAX_GREEN=4
      do_reset();
      cars(CAR_RED, CAR_RED);
      for (int i = 1; i <= 4; i++) begin
         cars(CAR_GREEN, CAR_RED);
         check_eq($sformatf("s4_ok_%0d", i), int'(fault4), 0);
      end
      cars(CAR_GREEN, CAR_RED);
      check_eq("s4_fault", int'(fault4), 1);
      check_eq("s4_code", int'(fault_code4), 5);
      check_eq("s4_default_ok", int'(fault), 0);

      // Scenario 5: cycle wrap, then fault counter saturation
      do_reset();
      cars(CAR_RED, CAR_RED);
      for (int c = 1; c <= 130; c++) begin
         cars(CAR_GREEN, CAR_RED);
         cars(CAR_YELLOW, CAR_RED);
         cars(CAR_RED, CAR_RED);
         if (c == 127) check_eq("s5_cycle127", int'(cycle), 127);
         if (c == 128) check_eq("s5_cycle_wrap", int'(cycle), 0);
      end
      check_eq("s5_cycle130", int'(cycle), 2);
      for (int k = 1; k <= 256; k++) begin
         cars(CAR_INVALID, CAR_RED);
         if (k == 1)   check_eq("s5_cnt1", int'(fault_cnt), 1);
         if (k == 255) check_eq("s5_cnt255", int'(fault_cnt), 255);
         step(CAR_RED, CAR_RED, PED_STOP, PED_STOP, 1'b1);
         cars(CAR_RED, CAR_RED);
      end
      check_eq("s5_cnt_sat", int'(fault_cnt), 255);

      // Scenario 6: asynchronous reset while in FAULT
      cars(CAR_INVALID, CAR_RED);
      check_eq("s6_pre_fault", int'(fault), 1);
      #2 rst = 1'b1;
      #1;
      check_eq("s6_fault", int'(fault), 0);
      check_eq("s6_code", int'(fault_code), 0);
      check_eq("s6_cnt", int'(fault_cnt), 0);
      check_eq("s6_cycle", int'(cycle), 0);
      check_eq("s6_pulse", int'(cycle_pulse), 0);
      check_eq("s6_state", int'(st), int'(ST_IDLE));
      @(posedge clk); #1;
      rst = 1'b0;
      cars(CAR_GREEN, CAR_RED);
      check_eq("s6_wait_idle", int'(st), int'(ST_IDLE));
      cars(CAR_RED, CAR_RED);
      check_eq("s6_run", int'(st), int'(ST_RUN));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
